// File: rtl/lsu_bus_ctrl.sv
// Load/store bus controller: one request at a time, PMA/alignment screening,
// commit gating for non-idempotent regions, single AHB-Lite transfer with optional timeout.
module lsu_bus_ctrl #(
   parameter int unsigned BUS_TIMEOUT = 0
) (
   input  logic        s_clk_i,
   input  logic        s_reset_i,
   input  logic        s_req_valid_i,
   output logic        s_req_ready_o,
   input  logic [31:0] s_req_addr_i,
   input  logic        s_req_write_i,
   input  logic [1:0]  s_req_size_i,
   input  logic        s_req_unsigned_i,
   input  logic [31:0] s_req_wdata_i,
   input  logic        s_commit_i,
   input  logic        s_flush_i,
   output logic [31:0] s_pma_address_o,
   output logic        s_pma_write_o,
   input  logic        s_pma_violation_i,
   input  logic        s_pma_idempotent_i,
   output logic [31:0] s_haddr_o,
   output logic [1:0]  s_htrans_o,
   output logic        s_hwrite_o,
   output logic [2:0]  s_hsize_o,
   output logic [31:0] s_hwdata_o,
   input  logic        s_hready_i,
   input  logic        s_hresp_i,
   input  logic [31:0] s_hrdata_i,
   output logic        s_rsp_valid_o,
   output logic [31:0] s_rsp_rdata_o,
   output logic [1:0]  s_rsp_ecode_o
);

   typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

   state_t      stateQ, stateD;
   logic [31:0] addrQ, addrD, wdataQ, wdataD, rdataQ, rdataD;
   logic [1:0]  sizeQ, sizeD, ecodeQ, ecodeD;
   logic [7:0]  timerQ, timerD;
   logic        writeQ, writeD, unsQ, unsD, commitQ, commitD;
   logic        issuedQ, issuedD, flushedQ, flushedD, sentQ, sentD;
   logic        rspValidQ, rspValidD;
   logic [1:0]  hTrans;
   logic        misaligned, flushNow;
   logic [31:0] shifted, loadData;

   always_comb begin
      shifted = s_hrdata_i >> {addrQ[1:0], 3'b000};
      case (sizeQ)
         2'd0:    loadData = unsQ ? {24'd0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
         2'd1:    loadData = unsQ ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
         default: loadData = shifted;
      endcase
      misaligned = (sizeQ == 2'd1 && addrQ[0]) || (sizeQ == 2'd2 && addrQ[1:0] != 2'd0)
                   || (sizeQ == 2'd3);
   end

   // A pending flush is remembered so a transfer already on the bus can finish silently.
   always_comb begin
      stateD    = stateQ;
      addrD     = addrQ;
      wdataD    = wdataQ;
      rdataD    = rdataQ;
      sizeD     = sizeQ;
      ecodeD    = ecodeQ;
      timerD    = timerQ;
      writeD    = writeQ;
      unsD      = unsQ;
      commitD   = commitQ;
      issuedD   = issuedQ;
      flushedD  = flushedQ;
      sentD     = sentQ;
      rspValidD = 1'b0;
      hTrans    = 2'b00;
      flushNow  = s_flush_i | flushedQ;
      case (stateQ)
         IDLE: begin
            if (s_req_valid_i) begin
               addrD    = s_req_addr_i;
               writeD   = s_req_write_i;
               sizeD    = s_req_size_i;
               unsD     = s_req_unsigned_i;
               wdataD   = s_req_wdata_i;
               commitD  = 1'b0;
               issuedD  = 1'b0;
               flushedD = s_flush_i;
               sentD    = 1'b0;
               stateD   = ADDR;
            end
         end
         ADDR: begin
            commitD = commitQ | s_commit_i;
            if (issuedQ) begin
               hTrans   = 2'b10;
               flushedD = flushNow;
               if (s_hready_i) begin
                  stateD  = DATA;
                  timerD  = 8'd0;
                  issuedD = 1'b0;
               end
            end else if (flushNow) begin
               stateD = IDLE;
            end else if (misaligned || s_pma_violation_i) begin
               stateD    = RESP;
               rspValidD = 1'b1;
               ecodeD    = misaligned ? 2'b01 : 2'b10;
               rdataD    = 32'd0;
            end else if (s_pma_idempotent_i || commitQ || s_commit_i) begin
               hTrans = 2'b10;
               if (s_hready_i) begin
                  stateD = DATA;
                  timerD = 8'd0;
               end else begin
                  issuedD = 1'b1;
               end
            end
         end
         DATA: begin
            flushedD = flushNow;
            if (!sentQ) begin
               timerD = timerQ + 8'd1;
            end
            if (s_hready_i) begin
               stateD = IDLE;
               if (!sentQ && !flushNow) begin
                  stateD    = RESP;
                  rspValidD = 1'b1;
                  ecodeD    = s_hresp_i ? 2'b11 : 2'b00;
                  rdataD    = (s_hresp_i || writeQ) ? 32'd0 : loadData;
               end
            end else if (BUS_TIMEOUT != 0 && timerQ == 8'(BUS_TIMEOUT) && !sentQ) begin
               sentD = 1'b1;
               if (!flushNow) begin
                  rspValidD = 1'b1;
                  ecodeD    = 2'b11;
                  rdataD    = 32'd0;
               end
            end
         end
         RESP: begin
            stateD = IDLE;
         end
         default: stateD = IDLE;
      endcase
   end

   always_ff @(posedge s_clk_i) begin
      if (s_reset_i) begin
         stateQ    <= IDLE;
         addrQ     <= 32'd0;
         wdataQ    <= 32'd0;
         rdataQ    <= 32'd0;
         sizeQ     <= 2'd0;
         ecodeQ    <= 2'd0;
         timerQ    <= 8'd0;
         writeQ    <= 1'b0;
         unsQ      <= 1'b0;
         commitQ   <= 1'b0;
         issuedQ   <= 1'b0;
         flushedQ  <= 1'b0;
         sentQ     <= 1'b0;
         rspValidQ <= 1'b0;
      end else begin
         stateQ    <= stateD;
         addrQ     <= addrD;
         wdataQ    <= wdataD;
         rdataQ    <= rdataD;
         sizeQ     <= sizeD;
         ecodeQ    <= ecodeD;
         timerQ    <= timerD;
         writeQ    <= writeD;
         unsQ      <= unsD;
         commitQ   <= commitD;
         issuedQ   <= issuedD;
         flushedQ  <= flushedD;
         sentQ     <= sentD;
         rspValidQ <= rspValidD;
      end
   end

   always_comb begin
      case (sizeQ)
         2'd0:    s_hwdata_o = {4{wdataQ[7:0]}};
         2'd1:    s_hwdata_o = {2{wdataQ[15:0]}};
         default: s_hwdata_o = wdataQ;
      endcase
   end

   assign s_req_ready_o   = (stateQ == IDLE);
   assign s_pma_address_o = addrQ;
   assign s_pma_write_o   = writeQ;
   assign s_haddr_o       = addrQ;
   assign s_htrans_o      = hTrans;
   assign s_hwrite_o      = writeQ;
   assign s_hsize_o       = {1'b0, sizeQ};
   assign s_rsp_valid_o   = rspValidQ;
   assign s_rsp_rdata_o   = rdataQ;
   assign s_rsp_ecode_o   = ecodeQ;

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Bench for lsu_bus_ctrl: transaction-level timeline model plus a small AHB slave,
// directed cases first and then randomized requests.
module tb_lsu_bus_ctrl;

   logic        s_clk_i = 1'b0;
   logic        s_reset_i;
   logic        s_req_valid_i, s_req_ready_o, s_req_write_i, s_req_unsigned_i;
   logic [31:0] s_req_addr_i, s_req_wdata_i;
   logic [1:0]  s_req_size_i;
   logic        s_commit_i, s_flush_i;
   logic [31:0] s_pma_address_o;
   logic        s_pma_write_o, s_pma_violation_i, s_pma_idempotent_i;
   logic [31:0] s_haddr_o, s_hwdata_o, s_hrdata_i;
   logic [1:0]  s_htrans_o;
   logic        s_hwrite_o, s_hready_i, s_hresp_i;
   logic [2:0]  s_hsize_o;
   logic        s_rsp_valid_o;
   logic [31:0] s_rsp_rdata_o;
   logic [1:0]  s_rsp_ecode_o;

   int total = 0;
   int bad   = 0;

   always #5 s_clk_i = ~s_clk_i;

   lsu_bus_ctrl #(.BUS_TIMEOUT(4)) dut (
      .s_clk_i(s_clk_i), .s_reset_i(s_reset_i),
      .s_req_valid_i(s_req_valid_i), .s_req_ready_o(s_req_ready_o),
      .s_req_addr_i(s_req_addr_i), .s_req_write_i(s_req_write_i),
      .s_req_size_i(s_req_size_i), .s_req_unsigned_i(s_req_unsigned_i),
      .s_req_wdata_i(s_req_wdata_i), .s_commit_i(s_commit_i), .s_flush_i(s_flush_i),
      .s_pma_address_o(s_pma_address_o), .s_pma_write_o(s_pma_write_o),
      .s_pma_violation_i(s_pma_violation_i), .s_pma_idempotent_i(s_pma_idempotent_i),
      .s_haddr_o(s_haddr_o), .s_htrans_o(s_htrans_o), .s_hwrite_o(s_hwrite_o),
      .s_hsize_o(s_hsize_o), .s_hwdata_o(s_hwdata_o),
      .s_hready_i(s_hready_i), .s_hresp_i(s_hresp_i), .s_hrdata_i(s_hrdata_i),
      .s_rsp_valid_o(s_rsp_valid_o), .s_rsp_rdata_o(s_rsp_rdata_o), .s_rsp_ecode_o(s_rsp_ecode_o)
   );

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %h want %h", tag, observed, expected);
      end
   endtask

   // One request from acceptance to return to idle. Cycle 0 is the first cycle after acceptance;
   // flushAt = -1 flushes on the accept cycle, anything below -1 means no flush.
   task automatic applyStimulus(input logic [31:0] addr, input bit write, input int size, input bit uns,
                                input logic [31:0] wdata, input logic [31:0] hrdata,
                                input bit idem, input bit viol, input int commitAt,
                                input int addrWait, input int dataWait, input bit err, input int flushAt);
      bit          mis, blocked, issued, expRsp, done, inData, rdyNow;
      int          d, expEcode, expRspCycle, lastCycle, nsSeen, firstNs, rspSeen, rspCycle, dataCnt, nsCnt;
      logic [31:0] expRdata, expHwdata, sh;
      logic [1:0]  htNow;

      mis      = (size == 3) || (size == 1 && addr % 2 != 0) || (size == 2 && addr % 4 != 0);
      blocked  = mis || viol;
      expEcode = mis ? 1 : viol ? 2 : (dataWait > 4 || err) ? 3 : 0;
      d        = (blocked || idem) ? 0 : commitAt;
      issued   = !blocked && !(flushAt >= -1 && flushAt <= d);
      if (blocked) begin
         expRspCycle = 1;
         expRsp      = !(flushAt >= -1 && flushAt <= 0);
      end else if (!issued) begin
         expRspCycle = -1;
         expRsp      = 1'b0;
      end else begin
         lastCycle   = (dataWait > 4) ? d + addrWait + 1 + 4 : d + addrWait + 1 + dataWait;
         expRspCycle = lastCycle + 1;
         expRsp      = !(flushAt >= -1 && flushAt <= lastCycle);
      end

      sh = hrdata >> (8 * (addr % 4));
      if (expEcode != 0 || write) expRdata = 0;
      else if (size == 0) expRdata = (!uns && (sh & 32'h80) != 0) ? ((sh & 32'hFF) | 32'hFFFFFF00) : (sh & 32'hFF);
      else if (size == 1) expRdata = (!uns && (sh & 32'h8000) != 0) ? ((sh & 32'hFFFF) | 32'hFFFF0000) : (sh & 32'hFFFF);
      else expRdata = sh;
      if (size == 0) expHwdata = (wdata & 32'hFF) * 32'h01010101;
      else if (size == 1) expHwdata = (wdata & 32'hFFFF) * 32'h00010001;
      else expHwdata = wdata;

      @(negedge s_clk_i);
      s_req_valid_i = 1'b1; s_req_addr_i = addr; s_req_write_i = write; s_req_size_i = 2'(size);
      s_req_unsigned_i = uns; s_req_wdata_i = wdata; s_commit_i = 1'b0; s_flush_i = (flushAt == -1);
      s_pma_violation_i = viol; s_pma_idempotent_i = idem; s_hrdata_i = hrdata;
      s_hready_i = 1'b1; s_hresp_i = 1'b0;
      #1 checkOutput("req_ready", 32'(s_req_ready_o), 32'd1);
      @(posedge s_clk_i);

      nsSeen = 0; firstNs = -1; rspSeen = 0; rspCycle = -1; done = 0;
      inData = 0; dataCnt = 0; nsCnt = 0;
      for (int c = 0; c < 80; c++) begin
         @(negedge s_clk_i);
         s_req_valid_i = 1'b0; s_commit_i = (c >= commitAt); s_flush_i = (c == flushAt);
         #1;
         if (c == 0) begin
            checkOutput("pma_addr", s_pma_address_o, addr);
            checkOutput("pma_write", 32'(s_pma_write_o), 32'(write));
         end
         htNow = s_htrans_o;
         if (inData) begin
            s_hready_i = (dataCnt == dataWait);
            s_hresp_i  = err && (dataCnt == dataWait);
         end else if (htNow == 2'b10) begin
            s_hready_i = (nsCnt >= addrWait);
            s_hresp_i  = 1'b0;
         end else begin
            s_hready_i = 1'b1;
            s_hresp_i  = 1'b0;
         end
         rdyNow = s_hready_i;
         #1;
         if (htNow == 2'b10) begin
            nsSeen++;
            if (firstNs < 0) firstNs = c;
            checkOutput("haddr", s_haddr_o, addr);
            checkOutput("hwrite", 32'(s_hwrite_o), 32'(write));
            checkOutput("hsize", 32'(s_hsize_o), 32'(size));
         end
         if (inData && rdyNow && write) checkOutput("hwdata", s_hwdata_o, expHwdata);
         if (s_rsp_valid_o) begin
            rspSeen++;
            rspCycle = c;
            checkOutput("ecode", 32'(s_rsp_ecode_o), 32'(expEcode));
            checkOutput("rdata", s_rsp_rdata_o, expRdata);
         end
         if (c > 0 && s_req_ready_o) begin
            done = 1;
            break;
         end
         @(posedge s_clk_i);
         if (inData) begin
            if (rdyNow) inData = 0; else dataCnt++;
         end else if (htNow == 2'b10) begin
            if (rdyNow) begin inData = 1; dataCnt = 0; end else nsCnt++;
         end
      end
      checkOutput("back_to_idle", 32'(done), 32'd1);
      checkOutput("rsp_count", 32'(rspSeen), expRsp ? 32'd1 : 32'd0);
      if (expRsp) checkOutput("rsp_cycle", 32'(rspCycle), 32'(expRspCycle));
      checkOutput("nonseq_count", 32'(nsSeen), issued ? 32'(addrWait + 1) : 32'd0);
      if (issued) checkOutput("nonseq_cycle", 32'(firstNs), 32'(d));
   endtask

   initial begin
      s_reset_i = 1'b1; s_req_valid_i = 1'b0; s_req_addr_i = 0; s_req_write_i = 0; s_req_size_i = 0;
      s_req_unsigned_i = 0; s_req_wdata_i = 0; s_commit_i = 0; s_flush_i = 0;
      s_pma_violation_i = 0; s_pma_idempotent_i = 1; s_hready_i = 1; s_hresp_i = 0; s_hrdata_i = 0;
      repeat (3) @(posedge s_clk_i);
      @(negedge s_clk_i);
      s_reset_i = 1'b0;
      #1;
      checkOutput("rst_ready", 32'(s_req_ready_o), 32'd1);
      checkOutput("rst_htrans", 32'(s_htrans_o), 32'd0);
      checkOutput("rst_rsp_valid", 32'(s_rsp_valid_o), 32'd0);
      checkOutput("rst_rdata", s_rsp_rdata_o, 32'd0);
      checkOutput("rst_ecode", 32'(s_rsp_ecode_o), 32'd0);

      applyStimulus(32'h0000_0104, 0, 2, 0, 0, 32'h1234_5678, 1, 0, 0, 0, 0, 0, -5);
      applyStimulus(32'h0000_0203, 0, 0, 0, 0, 32'h8011_2233, 1, 0, 0, 0, 0, 0, -5);
      applyStimulus(32'h0000_0203, 0, 0, 1, 0, 32'h8011_2233, 1, 0, 0, 0, 0, 0, -5);
      applyStimulus(32'h0000_0402, 0, 1, 0, 0, 32'h8001_7FFF, 1, 0, 0, 0, 1, 0, -5);
      applyStimulus(32'h0000_0301, 1, 1, 0, 32'hAAAA_5555, 0, 1, 0, 0, 0, 0, 0, -5);
      applyStimulus(32'h0000_0500, 1, 2, 0, 32'hDEAD_BEEF, 0, 1, 1, 0, 0, 0, 0, -5);
      applyStimulus(32'h0000_0601, 1, 0, 0, 32'h0000_00A5, 0, 1, 0, 0, 1, 2, 0, -5);
      applyStimulus(32'h0000_0700, 0, 2, 0, 0, 32'hCAFE_F00D, 0, 0, 5, 0, 0, 0, -5);
      applyStimulus(32'h0000_0704, 0, 2, 0, 0, 32'hCAFE_F00D, 0, 0, 99, 0, 0, 0, 3);
      applyStimulus(32'h0000_0800, 0, 2, 0, 0, 32'h1111_2222, 1, 0, 0, 0, 10, 0, -5);
      applyStimulus(32'h0000_0804, 0, 2, 0, 0, 32'h1111_2222, 1, 0, 0, 0, 1, 1, -5);
      applyStimulus(32'h0000_0900, 0, 2, 0, 0, 32'h3333_4444, 1, 0, 0, 3, 0, 0, 1);
      applyStimulus(32'h0000_0A00, 1, 2, 0, 32'h5555_6666, 0, 1, 0, 0, 0, 0, 0, -1);
      applyStimulus(32'h0000_0B02, 0, 3, 0, 0, 32'h0, 1, 0, 0, 0, 0, 0, -5);

      for (int n = 0; n < 60; n++) begin
         logic [31:0] rAddr;
         int          rFlush;
         rAddr = $urandom;
         if ($urandom_range(0, 3) != 0) rAddr = rAddr & 32'hFFFF_FFFC;
         rFlush = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 11)) - 1 : -5;
         applyStimulus(rAddr, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)), $urandom, $urandom,
                       ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
                       int'($urandom_range(0, 5)), int'($urandom_range(0, 2)),
                       int'($urandom_range(0, 7)), ($urandom_range(0, 5) == 0), rFlush);
      end

      @(negedge s_clk_i);
      s_req_valid_i = 1'b1; s_req_addr_i = 32'h0000_0C00; s_req_write_i = 0; s_req_size_i = 2'd2;
      s_pma_violation_i = 0; s_pma_idempotent_i = 1; s_flush_i = 0; s_hready_i = 1;
      @(posedge s_clk_i);
      @(negedge s_clk_i);
      s_req_valid_i = 1'b0; s_hready_i = 1'b0;
      #1 checkOutput("pre_reset_htrans", 32'(s_htrans_o), 32'h2);
      s_reset_i = 1'b1;
      @(posedge s_clk_i);
      @(negedge s_clk_i);
      s_reset_i = 1'b0; s_hready_i = 1'b1;
      #1;
      checkOutput("mid_reset_htrans", 32'(s_htrans_o), 32'd0);
      checkOutput("mid_reset_ready", 32'(s_req_ready_o), 32'd1);
      checkOutput("mid_reset_rsp", 32'(s_rsp_valid_o), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
